rtc_poller: RTL and testbench
=============================

Name: rtc_poller

Overview:
Memory-bus initiator that periodically reads the BCD mm:ss time register of the RTC peripheral and publishes a validated local copy. It sits between the RTC's bus slave port and consumers such as the display driver and attack/alarm logic. On each poll it detects changes, checks BCD ranges and flags an alarm match. It also watches for a bus timeout.

Parameters:
RTC_ADDR, 32'h0000_0000, bus address driven during every poll read.
POLL_INTERVAL, 1000, idle clock cycles between polls; legal range is 1 or more.
TIMEOUT, 16, cycles sel_out may stay high without ready_in before the read is abandoned; legal range is 1 or more.

Ports:
clk_in  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  polling enable
alarm_bcd_in  in  16  alarm compare value {minHi,minLo,secHi,secLo}
alarm_arm_in  in  1  alarm compare enable
address_out  out  32  bus address
sel_out  out  1  bus select / request
write_mask_out  out  4  bus write mask, constant 4'b0000 (read-only initiator)
write_value_out  out  32  bus write data, constant 0
read_value_in  in  32  bus read data
ready_in  in  1  bus completion
time_bcd_out  out  16  last valid time sample
time_valid_out  out  1  high once any valid sample has been captured
changed_out  out  1  1-cycle pulse when a new valid sample differs from the previous one
alarm_out  out  1  1-cycle pulse when the alarm match is entered
format_error_out  out  1  sticky; set when a sample fails BCD validation
timeout_error_out  out  1  sticky; set when a read times out

Behaviour:
- Reset: clk_in, reset is synchronous and active-high. Every output and internal register goes to 0 at the clock edge where reset is high, including while a read is outstanding. The FSM goes to IDLE. Both sticky errors are cleared only by reset.
- FSM states: IDLE, REQ, CHECK.
- IDLE:
  - With enable=0, the interval counter is held at 0.
  - With enable=1, the counter increments each cycle.
  - When the counter is POLL_INTERVAL-1, the counter clears and the FSM moves to REQ.
- REQ:
  - sel_out=1 and address_out=RTC_ADDR. address_out is 0 in all other states.
  - On any REQ cycle with ready_in=1, read_value_in is captured into the sample register and the FSM moves to CHECK. sel_out is low in the next cycle.
  - A wait counter counts REQ cycles with ready_in=0. When it reaches TIMEOUT: set timeout_error_out, drop sel_out, go to IDLE. Outputs keep their previous values.
  - Dropping enable during REQ does not abort the read.
- Responder ready is combinational on sel, so a normal read holds sel_out for exactly 1 cycle.
- Latency: sel_out is high in cycle N. CHECK executes in N+1. Updated outputs and pulses are visible in N+2.
- Poll period with an immediate ready: POLL_INTERVAL+2 cycles.
- CHECK, validity rule: a sample is valid only if all of these hold:
  - bits[31:16] are 0;
  - secLo ≤ 9;
  - secHi ≤ 5;
  - minLo ≤ 9;
  - minHi ≤ 5.
- CHECK, invalid sample: set format_error_out. time_bcd_out is unchanged and no pulses are generated.
- CHECK, valid sample:
  - time_bcd_out ← sample and time_valid_out ← 1.
  - changed_out pulses if time_valid_out was 0 or the sample differs from time_bcd_out.
  - alarm_out pulses if alarm_arm_in=1, sample==alarm_bcd_in and the change condition holds. A match that persists across polls fires once.
  - A wrap from 59:59 to 00:00 is treated as an ordinary change.
- After CHECK the FSM returns to IDLE.
- Pulses are single-cycle and never back-to-back, because CHECK is at most every POLL_INTERVAL+2 cycles.

Test Plan:
1. Reset, enable=1, POLL_INTERVAL=4, responder returns 32'h0000_0259 with ready=sel -> sel_out high for exactly 1 cycle with address_out=RTC_ADDR; 2 cycles later time_bcd_out=16'h0259, time_valid_out=1, changed_out single pulse; the next sel 6 cycles after the first.
2. Two consecutive polls return 0x0259 -> no changed_out pulse on the second poll. The next poll returns 0x0300 -> changed_out pulses and time_bcd_out=16'h0300.
3. alarm_arm_in=1, alarm_bcd_in=16'h0130, three polls return 0x0130 -> exactly one alarm_out pulse. Repeat with arm=0 -> no pulse, but changed_out still pulses.
4. Responder returns 0x0000_0060, then 0x0001_0259 -> format_error_out set after the first; time_bcd_out keeps its prior value through both. A subsequent 0x0101 is accepted, and format_error_out stays 1.
5. ready_in forced 0, TIMEOUT=16 -> sel_out high for exactly 16 cycles then low and timeout_error_out=1. With ready restored, the next poll completes normally.
6. reset asserted while sel_out=1 -> on the next cycle sel_out=0, all outputs 0, FSM IDLE. The first sel after reset release appears POLL_INTERVAL cycles after enable is seen high.

Source files
------------

// File: rtl/rtc_poller.sv
// rtc_poller: polls the RTC mm:ss BCD register, validates it and publishes a local copy with change/alarm pulses.
// Latency: sample captured in the sel cycle N, outputs and pulses visible in N+2; a stalled read is abandoned after TIMEOUT cycles.
module rtc_poller #(
    parameter logic [31:0] RTC_ADDR      = 32'h0000_0000,
    parameter int          POLL_INTERVAL = 1000,
    parameter int          TIMEOUT       = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] alarm_bcd_in,
    input  logic        alarm_arm_in,
    output logic [31:0] address_out,
    output logic        sel_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in,
    output logic [15:0] time_bcd_out,
    output logic        time_valid_out,
    output logic        changed_out,
    output logic        alarm_out,
    output logic        format_error_out,
    output logic        timeout_error_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Counters only ever reach PARAM-1, so clog2(PARAM) bits are enough.
    localparam int CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(POLL_INTERVAL - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [31:0]   sample_q, sample_d;
    logic [15:0]   time_q, time_d;
    logic          valid_q, valid_d;
    logic          changed_q, changed_d;
    logic          alarm_q, alarm_d;
    logic          fmt_err_q, fmt_err_d;
    logic          to_err_q, to_err_d;
    logic          is_new;

    function automatic logic bcd_ok(input logic [31:0] s);
        return (s[31:16] == 16'h0000) &&
               (s[3:0]   <= 4'd9)    &&
               (s[7:4]   <= 4'd5)    &&
               (s[11:8]  <= 4'd9)    &&
               (s[15:12] <= 4'd5);
    endfunction

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            sample_q  <= '0;
            time_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            alarm_q   <= 1'b0;
            fmt_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            sample_q  <= sample_d;
            time_q    <= time_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            alarm_q   <= alarm_d;
            fmt_err_q <= fmt_err_d;
            to_err_q  <= to_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        sample_d  = sample_q;
        time_d    = time_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        alarm_d   = 1'b0;
        fmt_err_d = fmt_err_q;
        to_err_d  = to_err_q;
        is_new    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!enable) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    wait_d  = '0;
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // enable is deliberately ignored here: an issued read always completes or times out.
            REQ: begin
                if (ready_in) begin
                    sample_d = read_value_in;
                    wait_d   = '0;
                    state_d  = CHECK;
                end else if (wait_q == WAIT_LAST) begin
                    to_err_d = 1'b1;
                    wait_d   = '0;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            CHECK: begin
                state_d = IDLE;
                if (bcd_ok(sample_q)) begin
                    is_new    = !valid_q || (sample_q[15:0] != time_q);
                    time_d    = sample_q[15:0];
                    valid_d   = 1'b1;
                    changed_d = is_new;
                    // Gating on is_new makes a persistent match fire only once.
                    alarm_d   = is_new && alarm_arm_in && (sample_q[15:0] == alarm_bcd_in);
                end else begin
                    fmt_err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel_out           = (state_q == REQ);
    assign address_out       = (state_q == REQ) ? RTC_ADDR : 32'h0000_0000;
    assign write_mask_out    = 4'b0000;
    assign write_value_out   = 32'h0000_0000;
    assign time_bcd_out      = time_q;
    assign time_valid_out    = valid_q;
    assign changed_out       = changed_q;
    assign alarm_out         = alarm_q;
    assign format_error_out  = fmt_err_q;
    assign timeout_error_out = to_err_q;

endmodule

// File: tb/tb_rtc_poller.sv
// Directed bench for rtc_poller with POLL_INTERVAL=4, TIMEOUT=16 and a responder whose ready follows sel.
module tb_rtc_poller;

    localparam logic [31:0] ADDR = 32'h4000_0010;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] alarm_bcd_in;
    logic        alarm_arm_in;
    logic [31:0] address_out;
    logic        sel_out;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic [31:0] read_value_in;
    logic        ready_in;
    logic [15:0] time_bcd_out;
    logic        time_valid_out;
    logic        changed_out;
    logic        alarm_out;
    logic        format_error_out;
    logic        timeout_error_out;

    logic        rdy_en;
    logic [31:0] resp_val;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sel_cyc = 0;
    int nsel, chg, alm;
    int c0, prev_sel;
    logic [31:0] sel_addr, sel_wv;
    logic [3:0]  sel_wm;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    assign ready_in      = sel_out & rdy_en;
    assign read_value_in = resp_val;

    rtc_poller #(
        .RTC_ADDR(ADDR),
        .POLL_INTERVAL(4),
        .TIMEOUT(16)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .enable(enable),
        .alarm_bcd_in(alarm_bcd_in),
        .alarm_arm_in(alarm_arm_in),
        .address_out(address_out),
        .sel_out(sel_out),
        .write_mask_out(write_mask_out),
        .write_value_out(write_value_out),
        .read_value_in(read_value_in),
        .ready_in(ready_in),
        .time_bcd_out(time_bcd_out),
        .time_valid_out(time_valid_out),
        .changed_out(changed_out),
        .alarm_out(alarm_out),
        .format_error_out(format_error_out),
        .timeout_error_out(timeout_error_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for the next sel, records its length, then counts pulses over the two following cycles.
    task automatic do_poll(input logic [31:0] val);
        int n;
        resp_val = val;
        n = 0;
        while (sel_out !== 1'b1 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 200) chk("sel_wait", {31'b0, sel_out}, 32'd1);
        sel_cyc  = cyc;
        sel_addr = address_out;
        sel_wm   = write_mask_out;
        sel_wv   = write_value_out;
        nsel = 0;
        while (sel_out === 1'b1 && nsel < 40) begin
            nsel++;
            @(negedge clk_in);
        end
        chg = 0;
        alm = 0;
        repeat (2) begin
            @(negedge clk_in);
            chg += int'(changed_out);
            alm += int'(alarm_out);
        end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        alarm_bcd_in = 16'h0000;
        alarm_arm_in = 1'b0;
        rdy_en       = 1'b1;
        resp_val     = 32'h0;
        repeat (2) @(negedge clk_in);

        chk("rst_sel", {31'b0, sel_out}, 32'd0);
        chk("rst_addr", address_out, 32'd0);
        chk("rst_time", {16'b0, time_bcd_out}, 32'd0);
        chk("rst_valid", {31'b0, time_valid_out}, 32'd0);
        chk("rst_errs", {30'b0, format_error_out, timeout_error_out}, 32'd0);

        // 1: first poll
        reset  = 1'b0;
        enable = 1'b1;
        c0     = cyc;
        do_poll(32'h0000_0259);
        chk("t1_first_sel_delay", sel_cyc - c0, 32'd4);
        chk("t1_nsel", nsel, 32'd1);
        chk("t1_addr", sel_addr, ADDR);
        chk("t1_wmask", {28'b0, sel_wm}, 32'd0);
        chk("t1_wval", sel_wv, 32'd0);
        chk("t1_time", {16'b0, time_bcd_out}, 32'h0259);
        chk("t1_valid", {31'b0, time_valid_out}, 32'd1);
        chk("t1_chg", chg, 32'd1);
        prev_sel = sel_cyc;

        // 2: repeat value gives no change, new value does
        do_poll(32'h0000_0259);
        chk("t1_period", sel_cyc - prev_sel, 32'd6);
        chk("t2_same_chg", chg, 32'd0);
        chk("t2_same_time", {16'b0, time_bcd_out}, 32'h0259);
        do_poll(32'h0000_0300);
        chk("t2_new_chg", chg, 32'd1);
        chk("t2_new_time", {16'b0, time_bcd_out}, 32'h0300);

        // 3: alarm fires once across a persistent match
        alarm_arm_in = 1'b1;
        alarm_bcd_in = 16'h0130;
        do_poll(32'h0000_0130);
        chk("t3_alm_p1", alm, 32'd1);
        chk("t3_chg_p1", chg, 32'd1);
        do_poll(32'h0000_0130);
        chk("t3_alm_p2", alm, 32'd0);
        do_poll(32'h0000_0130);
        chk("t3_alm_p3", alm, 32'd0);
        alarm_arm_in = 1'b0;
        do_poll(32'h0000_0200);
        chk("t3_disarm_chg_a", chg, 32'd1);
        do_poll(32'h0000_0130);
        chk("t3_disarm_chg_b", chg, 32'd1);
        chk("t3_disarm_alm", alm, 32'd0);

        // 4: BCD validation
        do_poll(32'h0000_0060);
        chk("t4_sec60_fmt", {31'b0, format_error_out}, 32'd1);
        chk("t4_sec60_time", {16'b0, time_bcd_out}, 32'h0130);
        chk("t4_sec60_chg", chg, 32'd0);
        do_poll(32'h0001_0259);
        chk("t4_upper_time", {16'b0, time_bcd_out}, 32'h0130);
        chk("t4_upper_chg", chg, 32'd0);
        do_poll(32'h0000_0101);
        chk("t4_ok_time", {16'b0, time_bcd_out}, 32'h0101);
        chk("t4_ok_chg", chg, 32'd1);
        chk("t4_fmt_sticky", {31'b0, format_error_out}, 32'd1);
        do_poll(32'h0000_5959);
        chk("t4_max_time", {16'b0, time_bcd_out}, 32'h5959);
        do_poll(32'h0000_0000);
        chk("t4_wrap_time", {16'b0, time_bcd_out}, 32'h0000);
        chk("t4_wrap_chg", chg, 32'd1);
        do_poll(32'h0000_0A00);
        chk("t4_minlo_time", {16'b0, time_bcd_out}, 32'h0000);
        chk("t4_minlo_chg", chg, 32'd0);

        // 5: timeout, then recovery
        rdy_en = 1'b0;
        do_poll(32'h0000_0333);
        chk("t5_nsel", nsel, 32'd16);
        chk("t5_to_err", {31'b0, timeout_error_out}, 32'd1);
        chk("t5_time", {16'b0, time_bcd_out}, 32'h0000);
        chk("t5_chg", chg, 32'd0);
        rdy_en = 1'b1;
        do_poll(32'h0000_0102);
        chk("t5_rec_nsel", nsel, 32'd1);
        chk("t5_rec_time", {16'b0, time_bcd_out}, 32'h0102);
        chk("t5_rec_chg", chg, 32'd1);
        chk("t5_to_sticky", {31'b0, timeout_error_out}, 32'd1);

        // 6: reset during an outstanding read
        rdy_en = 1'b0;
        c0 = 0;
        while (sel_out !== 1'b1 && c0 < 200) begin
            @(negedge clk_in);
            c0++;
        end
        chk("t6_sel_seen", {31'b0, sel_out}, 32'd1);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        chk("t6_sel", {31'b0, sel_out}, 32'd0);
        chk("t6_addr", address_out, 32'd0);
        chk("t6_time", {16'b0, time_bcd_out}, 32'd0);
        chk("t6_flags", {27'b0, time_valid_out, changed_out, alarm_out,
                         format_error_out, timeout_error_out}, 32'd0);
        reset  = 1'b0;
        rdy_en = 1'b1;
        c0     = cyc;
        do_poll(32'h0000_0405);
        chk("t6_first_sel_delay", sel_cyc - c0, 32'd4);
        chk("t6_nsel", nsel, 32'd1);
        chk("t6_time_after", {16'b0, time_bcd_out}, 32'h0405);
        chk("t6_errs_after", {30'b0, format_error_out, timeout_error_out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
